// File: rtl/minirisc_core.sv
// Accumulator micro-core: LOAD/ADD/SUB/STORE/LDR, optional shift-add MUL (macro MINIRISC_MUL_EN).
// Latency: single-cycle ops visible on the accepting edge; MUL takes DATA_W cycles after acceptance.
// Backpressure: instr_ready low during reset, while ena is low, and while a MUL is iterating.
module minirisc_core #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    localparam int RS_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [RS_W-1:0]   reg_sel,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] acc_out,
    output logic              flag_z,
    output logic              flag_c,
    output logic              illegal,
    output logic              store_valid,
    output logic [DATA_W-1:0] store_data
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_STORE = 4'd4;
    localparam logic [3:0] OP_LDR   = 4'd5;
`ifdef MINIRISC_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'd6;
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_MUL    = 1'b1;
    localparam int         CNT_W    = $clog2(DATA_W) + 1;
`endif

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W:0]   add_res;
    logic [DATA_W:0]   sub_res;
    logic              accept;

    assign rs_val  = regs[reg_sel];
    assign add_res = {1'b0, acc} + {1'b0, rs_val};
    // The extra top bit of the widened subtraction is the unsigned borrow.
    assign sub_res = {1'b0, acc} - {1'b0, rs_val};

`ifdef MINIRISC_MUL_EN
    logic [0:0]          state;
    logic [2*DATA_W-1:0] mul_prod;
    logic [2*DATA_W-1:0] mul_mcand;
    logic [2*DATA_W-1:0] mul_sum;
    logic [DATA_W-1:0]   mul_mplr;
    logic [CNT_W-1:0]    mul_cnt;
    logic                mul_last;

    assign instr_ready = rst_n & ena & (state == S_IDLE);
    assign mul_sum     = mul_prod + (mul_mplr[0] ? mul_mcand : '0);
    assign mul_last    = (mul_cnt == CNT_W'(DATA_W - 1));
`else
    assign instr_ready = rst_n & ena;
`endif

    assign accept     = instr_valid & instr_ready;
    assign acc_out    = acc;
    assign flag_z     = (acc == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            flag_c      <= 1'b0;
            illegal     <= 1'b0;
            store_valid <= 1'b0;
            store_data  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
`ifdef MINIRISC_MUL_EN
            state     <= S_IDLE;
            mul_prod  <= '0;
            mul_mcand <= '0;
            mul_mplr  <= '0;
            mul_cnt   <= '0;
`endif
        end else begin
            // Strobe, not state: it drops on the next edge even if ena is low.
            store_valid <= 1'b0;
            if (accept) begin
                case (opcode)
                    OP_NOP: ;
                    OP_LOAD: acc <= imm;
                    OP_ADD: begin
                        acc    <= add_res[DATA_W-1:0];
                        flag_c <= add_res[DATA_W];
                    end
                    OP_SUB: begin
                        acc    <= sub_res[DATA_W-1:0];
                        flag_c <= sub_res[DATA_W];
                    end
                    OP_STORE: begin
                        regs[reg_sel] <= acc;
                        store_valid   <= 1'b1;
                        store_data    <= acc;
                    end
                    OP_LDR: acc <= rs_val;
`ifdef MINIRISC_MUL_EN
                    OP_MUL: begin
                        state     <= S_MUL;
                        mul_prod  <= '0;
                        mul_mcand <= {{DATA_W{1'b0}}, acc};
                        mul_mplr  <= rs_val;
                        mul_cnt   <= '0;
                    end
`endif
                    default: illegal <= 1'b1;
                endcase
            end
`ifdef MINIRISC_MUL_EN
            else if (state == S_MUL && ena) begin
                mul_prod  <= mul_sum;
                mul_mcand <= mul_mcand << 1;
                mul_mplr  <= mul_mplr >> 1;
                mul_cnt   <= mul_cnt + 1'b1;
                if (mul_last) begin
                    acc    <= mul_sum[DATA_W-1:0];
                    flag_c <= |mul_sum[2*DATA_W-1:DATA_W];
                    state  <= S_IDLE;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_minirisc_core.sv
// Scoreboard bench for minirisc_core: a software model pushes expectations, outputs are popped and compared.
module tb_minirisc_core;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rs;
        logic [7:0] imm;
    } ins_t;

    typedef struct packed {
        logic [7:0] acc;
        logic       c;
        logic       ill;
        logic       sv;
        logic [7:0] sd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] opcode = 4'd0;
    logic [1:0] reg_sel = 2'd0;
    logic [7:0] imm = 8'd0;
    logic [7:0] acc_out;
    logic       flag_z, flag_c, illegal, store_valid;
    logic [7:0] store_data;

    int vectors = 0;
    int miscompares = 0;

    exp_t sb[$];
    logic [7:0] m_acc;
    logic [7:0] m_r [4];
    logic       m_c, m_ill;
    logic [7:0] m_sd;

    always #5 clk = ~clk;

    minirisc_core #(.DATA_W(8), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .reg_sel(reg_sel), .imm(imm),
        .acc_out(acc_out), .flag_z(flag_z), .flag_c(flag_c),
        .illegal(illegal), .store_valid(store_valid), .store_data(store_data)
    );

    task automatic model_reset();
        m_acc = 8'h00; m_c = 1'b0; m_ill = 1'b0; m_sd = 8'h00;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    endtask

    task automatic model_step(input ins_t in);
        exp_t e;
        logic [15:0] prod;
        e.sv = 1'b0;
        case (in.op)
            4'd0: ;
            4'd1: m_acc = in.imm;
            4'd2: {m_c, m_acc} = {1'b0, m_acc} + {1'b0, m_r[in.rs]};
            4'd3: begin m_c = (m_acc < m_r[in.rs]); m_acc = m_acc - m_r[in.rs]; end
            4'd4: begin m_r[in.rs] = m_acc; m_sd = m_acc; e.sv = 1'b1; end
            4'd5: m_acc = m_r[in.rs];
`ifdef MINIRISC_MUL_EN
            4'd6: begin prod = m_acc * m_r[in.rs]; m_c = |prod[15:8]; m_acc = prod[7:0]; end
`endif
            default: m_ill = 1'b1;
        endcase
        e.acc = m_acc; e.c = m_c; e.ill = m_ill; e.sd = m_sd;
        sb.push_back(e);
    endtask

    // Drive one instruction, push its expectation on acceptance; returns #1 after the accepting edge.
    task automatic issue(input ins_t in);
        int budget = 0;
        @(negedge clk);
        opcode = in.op; reg_sel = in.rs; imm = in.imm; instr_valid = 1'b1;
        while (!(instr_ready && ena) && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 40) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout instr_ready=%b required 1", instr_ready);
            instr_valid = 1'b0;
            return;
        end
        model_step(in);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (acc_out !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b0 || illegal !== 1'b0 ||
            store_valid !== 1'b0 || store_data !== 8'h00 || instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state acc=%h z=%b c=%b ill=%b sv=%b sd=%h rdy=%b required acc=00 z=1 c=0 ill=0 sv=0 sd=00 rdy=0",
                     acc_out, flag_z, flag_c, illegal, store_valid, store_data, instr_ready);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready instr_ready=%b required 1", instr_ready);
        end
    endtask

    task automatic test_add_store();
        ins_t prog [4] = '{'{4'd1, 2'd0, 8'h05}, '{4'd4, 2'd1, 8'h00},
                           '{4'd1, 2'd0, 8'h03}, '{4'd2, 2'd1, 8'h00}};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(prog[i]);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            vectors++;
            if (acc_out !== e.acc || flag_c !== e.c || flag_z !== (e.acc == 8'h00)) begin
                miscompares++;
                $display("FAIL add_store[%0d] acc=%h c=%b z=%b required acc=%h c=%b z=%b",
                         i, acc_out, flag_c, flag_z, e.acc, e.c, (e.acc == 8'h00));
            end
            vectors++;
            if (store_valid !== e.sv || (e.sv && store_data !== e.sd)) begin
                miscompares++;
                $display("FAIL store_pulse[%0d] sv=%b sd=%h required sv=%b sd=%h",
                         i, store_valid, store_data, e.sv, e.sd);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (store_valid !== 1'b0 || acc_out !== 8'h08) begin
            miscompares++;
            $display("FAIL add_store_final sv=%b acc=%h required sv=0 acc=08", store_valid, acc_out);
        end
    endtask

    task automatic test_carry_borrow();
        ins_t prog [5] = '{'{4'd1, 2'd0, 8'hFF}, '{4'd4, 2'd0, 8'h00}, '{4'd1, 2'd0, 8'h02},
                           '{4'd2, 2'd0, 8'h00}, '{4'd3, 2'd0, 8'h00}};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(prog[i]);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            vectors++;
            if (acc_out !== e.acc || flag_c !== e.c || flag_z !== (e.acc == 8'h00)) begin
                miscompares++;
                $display("FAIL carry_borrow[%0d] acc=%h c=%b z=%b required acc=%h c=%b z=%b",
                         i, acc_out, flag_c, flag_z, e.acc, e.c, (e.acc == 8'h00));
            end
        end
    endtask

    task automatic test_illegal();
        ins_t prog [6] = '{'{4'd1, 2'd1, 8'h11}, '{4'd9, 2'd1, 8'h00}, '{4'd4, 2'd1, 8'h00},
                           '{4'd1, 2'd0, 8'h22}, '{4'd15, 2'd0, 8'hAA}, '{4'd2, 2'd1, 8'h00}};
        ins_t ldr;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(prog[i]);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            vectors++;
            if (acc_out !== e.acc || flag_c !== e.c || illegal !== e.ill) begin
                miscompares++;
                $display("FAIL illegal[%0d] acc=%h c=%b ill=%b required acc=%h c=%b ill=%b",
                         i, acc_out, flag_c, illegal, e.acc, e.c, e.ill);
            end
        end
        apply_reset();
        #1;
        vectors++;
        if (illegal !== 1'b0 || acc_out !== 8'h00) begin
            miscompares++;
            $display("FAIL illegal_cleared ill=%b acc=%h required ill=0 acc=00", illegal, acc_out);
        end
        for (int r = 0; r < 4; r++) begin
            ldr = '{4'd5, 2'(r), 8'h00};
            issue(ldr);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            vectors++;
            if (acc_out !== e.acc) begin
                miscompares++;
                $display("FAIL reg_reset[R%0d] acc=%h required %h", r, acc_out, e.acc);
            end
        end
    endtask

    task automatic test_ena_stall();
        ins_t pre [3] = '{'{4'd1, 2'd0, 8'h10}, '{4'd4, 2'd1, 8'h00}, '{4'd2, 2'd1, 8'h00}};
        ins_t add_r1 = '{4'd2, 2'd1, 8'h00};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(pre[i]);
            if (sb.size() != 0) e = sb.pop_front();
        end
        @(negedge clk);
        ena = 1'b0; opcode = 4'd2; reg_sel = 2'd1; instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (instr_ready !== 1'b0 || acc_out !== m_acc) begin
                miscompares++;
                $display("FAIL ena_hold[%0d] rdy=%b acc=%h required rdy=0 acc=%h", k, instr_ready, acc_out, m_acc);
            end
        end
        @(negedge clk);
        instr_valid = 1'b0; ena = 1'b1;
        issue(add_r1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if (acc_out !== e.acc || flag_c !== e.c) begin
                miscompares++;
                $display("FAIL ena_resume acc=%h c=%b required acc=%h c=%b", acc_out, flag_c, e.acc, e.c);
            end
        end
    endtask

    task automatic test_back_to_back();
        ins_t in;
        exp_t e;
        logic [3:0] ops [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        for (int i = 0; i < 30; i++) begin
            in.op  = ops[$urandom_range(0, 4)];
            in.rs  = 2'($urandom_range(0, 3));
            in.imm = 8'($urandom_range(0, 255));
            issue(in);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            vectors++;
            if (acc_out !== e.acc || flag_c !== e.c || flag_z !== (e.acc == 8'h00) ||
                store_valid !== e.sv || (e.sv && store_data !== e.sd)) begin
                miscompares++;
                $display("FAIL b2b[%0d] op=%0d acc=%h c=%b z=%b sv=%b sd=%h required acc=%h c=%b sv=%b sd=%h",
                         i, in.op, acc_out, flag_c, flag_z, store_valid, store_data, e.acc, e.c, e.sv, e.sd);
            end
        end
    endtask

`ifdef MINIRISC_MUL_EN
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [1:0] rs,
                           input bit gap, input string tag);
        ins_t pre [3];
        ins_t mul_i;
        exp_t e;
        int busy = 0;
        pre[0] = '{4'd1, 2'd0, b};
        pre[1] = '{4'd4, rs, 8'h00};
        pre[2] = '{4'd1, 2'd0, a};
        for (int i = 0; i < 3; i++) begin
            issue(pre[i]);
            if (sb.size() != 0) e = sb.pop_front();
        end
        mul_i = '{4'd6, rs, 8'h00};
        issue(mul_i);
        while (instr_ready === 1'b0 && busy < 40) begin
            if (gap && busy == 3) begin
                ena = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                ena = 1'b1;
            end
            @(posedge clk);
            #1;
            busy++;
        end
        vectors++;
        if (busy != 8) begin
            miscompares++;
            $display("FAIL %s busy_cycles=%0d required 8", tag, busy);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if (acc_out !== e.acc || flag_c !== e.c || flag_z !== (e.acc == 8'h00)) begin
                miscompares++;
                $display("FAIL %s acc=%h c=%b z=%b required acc=%h c=%b z=%b",
                         tag, acc_out, flag_c, flag_z, e.acc, e.c, (e.acc == 8'h00));
            end
        end
    endtask

    task automatic test_mul();
        run_mul(8'h06, 8'h07, 2'd2, 1'b0, "mul_7x6");
        run_mul(8'h10, 8'h20, 2'd3, 1'b1, "mul_20x10_stall");
        run_mul(8'hFF, 8'hFF, 2'd1, 1'b0, "mul_ffxff");
    endtask

    task automatic test_mul_reset();
        ins_t pre [3] = '{'{4'd1, 2'd0, 8'h07}, '{4'd4, 2'd2, 8'h00}, '{4'd1, 2'd0, 8'h05}};
        ins_t mul_i = '{4'd6, 2'd2, 8'h00};
        ins_t ldr;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(pre[i]);
            if (sb.size() != 0) e = sb.pop_front();
        end
        issue(mul_i);
        if (sb.size() != 0) e = sb.pop_front();
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (acc_out !== 8'h00 || flag_z !== 1'b1 || instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_reset acc=%h z=%b rdy=%b required acc=00 z=1 rdy=0", acc_out, flag_z, instr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (instr_ready !== 1'b1 || acc_out !== 8'h00) begin
            miscompares++;
            $display("FAIL mul_reset_release rdy=%b acc=%h required rdy=1 acc=00", instr_ready, acc_out);
        end
        for (int r = 0; r < 4; r++) begin
            ldr = '{4'd5, 2'(r), 8'h00};
            issue(ldr);
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            vectors++;
            if (acc_out !== e.acc) begin
                miscompares++;
                $display("FAIL mul_reg_reset[R%0d] acc=%h required %h", r, acc_out, e.acc);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_add_store();
        test_carry_borrow();
        test_illegal();
        test_ena_stall();
        test_back_to_back();
`ifdef MINIRISC_MUL_EN
        test_mul();
        test_mul_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
